// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// read-owner encoding, starvation counter sizing and the owner decode helper.
package mem_port_arbiter_pkg;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_t;

   localparam int            CNT_W   = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Which port, if any, expects read data back next cycle. Stores return nothing.
   function automatic owner_t read_owner(input logic fetch_grant,
                                         input logic data_grant,
                                         input logic data_wren);
      owner_t own;
      own = OWN_NONE;
      if (fetch_grant)
         own = OWN_FETCH;
      else if (data_grant && !data_wren)
         own = OWN_DATA;
      return own;
   endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles in which fetch was requesting but
// lost the memory port to mem_stage. at_limit tells the arbiter to let fetch win.
module arb_starve_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clear,
   output logic at_limit
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins over increment; increment stops at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (inc && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Counter register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port mem_controller between the srec loader (boot only),
// instruction fetch and mem_stage. During BOOT the loader owns the port
// outright; in RUN data accesses win unless fetch has been starved for
// STARVE_LIMIT cycles. Read data returns one cycle after the grant, steered
// to whichever port issued the read, with a one-cycle rvalid pulse.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [0:ADDR_WIDTH-1] loader_address,
   input  logic                  loader_wren,
   input  logic [0:DATA_WIDTH-1] loader_data,
   input  logic                  loader_done,
   input  logic                  fetch_req,
   input  logic [0:ADDR_WIDTH-1] fetch_address,
   output logic                  fetch_stall,
   output logic [0:DATA_WIDTH-1] fetch_rdata,
   output logic                  fetch_rvalid,
   input  logic                  data_req,
   input  logic                  data_wren,
   input  logic [0:ADDR_WIDTH-1] data_address,
   input  logic [0:DATA_WIDTH-1] data_wdata,
   output logic                  data_stall,
   output logic [0:DATA_WIDTH-1] data_rdata,
   output logic                  data_rvalid,
   output logic [0:ADDR_WIDTH-1] mcu_address,
   output logic                  mcu_wren,
   output logic [0:DATA_WIDTH-1] mcu_data_in,
   input  logic [0:DATA_WIDTH-1] mcu_data_out,
   output logic                  booting
);

   state_t                state_q;
   state_t                state_d;
   owner_t                rd_owner_q;
   owner_t                rd_owner_d;
   logic [0:DATA_WIDTH-1] fetch_rdata_q;
   logic [0:DATA_WIDTH-1] fetch_rdata_d;
   logic [0:DATA_WIDTH-1] data_rdata_q;
   logic [0:DATA_WIDTH-1] data_rdata_d;

   logic fetch_grant;
   logic data_grant;
   logic starve_at_limit;
   logic starve_inc;
   logic starve_clear;

   assign booting = (state_q == ST_BOOT);

   // BOOT is left once loader_done is seen; RUN is held until reset.
   always_comb begin
      state_d = state_q;
      if ((state_q == ST_BOOT) && loader_done)
         state_d = ST_RUN;
   end

   // Grant selection, memory port mux and stall generation.
   always_comb begin
      fetch_grant = 1'b0;
      data_grant  = 1'b0;
      mcu_address = fetch_address;
      mcu_wren    = 1'b0;
      mcu_data_in = data_wdata;
      fetch_stall = 1'b1;
      data_stall  = 1'b1;

      if (state_q == ST_BOOT) begin
         mcu_address = loader_address;
         mcu_wren    = loader_wren;
         mcu_data_in = loader_data;
      end else begin
         // Data has priority except when fetch has hit its starvation limit.
         if (data_req && !(fetch_req && starve_at_limit))
            data_grant = 1'b1;
         else if (fetch_req)
            fetch_grant = 1'b1;

         if (data_grant) begin
            mcu_address = data_address;
            mcu_wren    = data_wren;
            mcu_data_in = data_wdata;
         end else if (fetch_grant) begin
            mcu_address = fetch_address;
            mcu_wren    = 1'b0;
         end

         fetch_stall = fetch_req & ~fetch_grant;
         data_stall  = data_req & ~data_grant;
      end
   end

   assign starve_inc   = fetch_req & data_grant;
   assign starve_clear = fetch_grant | ~fetch_req;

   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clock    (clock),
      .reset    (reset),
      .inc      (starve_inc),
      .clear    (starve_clear),
      .at_limit (starve_at_limit)
   );

   // Read return: the owner registered at the grant edge claims mcu_data_out
   // in the following cycle; otherwise each port's rdata holds its last word.
   always_comb begin
      rd_owner_d    = read_owner(fetch_grant, data_grant, data_wren);
      fetch_rvalid  = (rd_owner_q == OWN_FETCH);
      data_rvalid   = (rd_owner_q == OWN_DATA);
      fetch_rdata   = fetch_rvalid ? mcu_data_out : fetch_rdata_q;
      data_rdata    = data_rvalid ? mcu_data_out : data_rdata_q;
      fetch_rdata_d = fetch_rdata;
      data_rdata_d  = data_rdata;
   end

   // State, read owner and held read data registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         rd_owner_q    <= OWN_NONE;
         fetch_rdata_q <= '0;
         data_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         rd_owner_q    <= rd_owner_d;
         fetch_rdata_q <= fetch_rdata_d;
         data_rdata_q  <= data_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory
// standing in for mem_controller (one-cycle read latency).
module tb_mem_port_arbiter;

   logic        clock;
   logic        reset;
   logic [0:31] loader_address;
   logic        loader_wren;
   logic [0:31] loader_data;
   logic        loader_done;
   logic        fetch_req;
   logic [0:31] fetch_address;
   logic        fetch_stall;
   logic [0:31] fetch_rdata;
   logic        fetch_rvalid;
   logic        data_req;
   logic        data_wren;
   logic [0:31] data_address;
   logic [0:31] data_wdata;
   logic        data_stall;
   logic [0:31] data_rdata;
   logic        data_rvalid;
   logic [0:31] mcu_address;
   logic        mcu_wren;
   logic [0:31] mcu_data_in;
   logic [0:31] mcu_data_out;
   logic        booting;

   int errors;
   int checks;

   mem_port_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .loader_address (loader_address),
      .loader_wren    (loader_wren),
      .loader_data    (loader_data),
      .loader_done    (loader_done),
      .fetch_req      (fetch_req),
      .fetch_address  (fetch_address),
      .fetch_stall    (fetch_stall),
      .fetch_rdata    (fetch_rdata),
      .fetch_rvalid   (fetch_rvalid),
      .data_req       (data_req),
      .data_wren      (data_wren),
      .data_address   (data_address),
      .data_wdata     (data_wdata),
      .data_stall     (data_stall),
      .data_rdata     (data_rdata),
      .data_rvalid    (data_rvalid),
      .mcu_address    (mcu_address),
      .mcu_wren       (mcu_wren),
      .mcu_data_in    (mcu_data_in),
      .mcu_data_out   (mcu_data_out),
      .booting        (booting)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural single-port memory: write on wren, registered read otherwise.
   logic [31:0] mem [logic [31:0]];
   logic [31:0] mem_a;
   always @(posedge clock) begin
      mem_a = mcu_address;
      if (mcu_wren)
         mem[mem_a] = mcu_data_in;
      mcu_data_out <= mem.exists(mem_a) ? mem[mem_a] : 32'h0;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      loader_address = '0; loader_wren = 1'b0; loader_data = '0; loader_done = 1'b0;
      fetch_req = 1'b0; fetch_address = '0;
      data_req = 1'b0; data_wren = 1'b0; data_address = '0; data_wdata = '0;
      #1;
      checks++; if (booting !== 1'b1) begin errors++; $display("FAIL reset_booting got=%b exp=1", booting); end
      checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL reset_fetch_stall got=%b exp=1", fetch_stall); end
      checks++; if (data_stall !== 1'b1) begin errors++; $display("FAIL reset_data_stall got=%b exp=1", data_stall); end
      checks++; if ({fetch_rvalid, data_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", fetch_rvalid, data_rvalid); end
      checks++; if (fetch_rdata !== 32'h0) begin errors++; $display("FAIL reset_fetch_rdata got=%h exp=0", fetch_rdata); end
      checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL reset_data_rdata got=%h exp=0", data_rdata); end
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_boot_load();
      loader_address = 32'h8002_0000; loader_wren = 1'b1; loader_data = 32'h2408_0005;
      fetch_req = 1'b1; fetch_address = 32'h8002_0000;
      @(negedge clock);
      checks++; if (mcu_address !== 32'h8002_0000) begin errors++; $display("FAIL boot_mcu_address got=%h exp=80020000", mcu_address); end
      checks++; if (mcu_wren !== 1'b1) begin errors++; $display("FAIL boot_mcu_wren got=%b exp=1", mcu_wren); end
      checks++; if (mcu_data_in !== 32'h2408_0005) begin errors++; $display("FAIL boot_mcu_data_in got=%h exp=24080005", mcu_data_in); end
      checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL boot_fetch_stall got=%b exp=1", fetch_stall); end
      checks++; if (booting !== 1'b1) begin errors++; $display("FAIL boot_booting got=%b exp=1", booting); end
      step();
      loader_wren = 1'b0;
   endtask

   task automatic test_boot_exit();
      loader_done = 1'b1;
      @(negedge clock);
      checks++; if (booting !== 1'b1) begin errors++; $display("FAIL exit_same_cycle_booting got=%b exp=1", booting); end
      checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL exit_same_cycle_fetch_stall got=%b exp=1", fetch_stall); end
      step();
      loader_done = 1'b0;
      @(negedge clock);
      checks++; if (booting !== 1'b0) begin errors++; $display("FAIL exit_booting got=%b exp=0", booting); end
      checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL exit_fetch_stall got=%b exp=0", fetch_stall); end
      checks++; if ({mcu_address, mcu_wren} !== {32'h8002_0000, 1'b0}) begin errors++; $display("FAIL exit_mcu got=%h/%b exp=80020000/0", mcu_address, mcu_wren); end
      step();
      fetch_req = 1'b0;
      @(negedge clock);
      checks++; if (fetch_rvalid !== 1'b1) begin errors++; $display("FAIL exit_fetch_rvalid got=%b exp=1", fetch_rvalid); end
      checks++; if (fetch_rdata !== 32'h2408_0005) begin errors++; $display("FAIL exit_fetch_rdata got=%h exp=24080005", fetch_rdata); end
      checks++; if (data_rvalid !== 1'b0) begin errors++; $display("FAIL exit_data_rvalid got=%b exp=0", data_rvalid); end
      step();
      @(negedge clock);
      checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL exit_pulse_width got=%b exp=0", fetch_rvalid); end
      checks++; if (fetch_rdata !== 32'h2408_0005) begin errors++; $display("FAIL exit_rdata_hold got=%h exp=24080005", fetch_rdata); end
      checks++; if (booting !== 1'b0) begin errors++; $display("FAIL exit_run_sticky got=%b exp=0", booting); end
      step();
   endtask

   task automatic test_starvation();
      logic [9:0] fetch_win;
      logic       prev_fw;
      fetch_win = 10'b10000_10000;
      fetch_req = 1'b1; fetch_address = 32'h8002_0000;
      data_req = 1'b1; data_wren = 1'b0; data_address = 32'h8002_0010;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         checks++; if (fetch_stall !== !fetch_win[i]) begin errors++; $display("FAIL starve_fetch_stall[%0d] got=%b exp=%b", i, fetch_stall, !fetch_win[i]); end
         checks++; if (data_stall !== fetch_win[i]) begin errors++; $display("FAIL starve_data_stall[%0d] got=%b exp=%b", i, data_stall, fetch_win[i]); end
         checks++; if (mcu_address !== (fetch_win[i] ? 32'h8002_0000 : 32'h8002_0010)) begin errors++; $display("FAIL starve_mcu_address[%0d] got=%h", i, mcu_address); end
         if (i > 0) begin
            prev_fw = fetch_win[i-1];
            checks++; if ({fetch_rvalid, data_rvalid} !== {prev_fw, !prev_fw}) begin errors++; $display("FAIL starve_rvalid[%0d] got=%b%b exp=%b%b", i, fetch_rvalid, data_rvalid, prev_fw, !prev_fw); end
         end
         step();
      end
      fetch_req = 1'b0; data_req = 1'b0;
      step();
   endtask

   task automatic test_store_load();
      data_req = 1'b1; data_wren = 1'b1; data_address = 32'h8002_0020; data_wdata = 32'hDEAD_BEEF;
      @(negedge clock);
      checks++; if ({mcu_wren, mcu_address, mcu_data_in} !== {1'b1, 32'h8002_0020, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_mcu got=%b/%h/%h exp=1/80020020/deadbeef", mcu_wren, mcu_address, mcu_data_in); end
      checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL store_data_stall got=%b exp=0", data_stall); end
      step();
      data_wren = 1'b0;
      @(negedge clock);
      checks++; if ({fetch_rvalid, data_rvalid} !== 2'b00) begin errors++; $display("FAIL store_no_rvalid got=%b%b exp=00", fetch_rvalid, data_rvalid); end
      checks++; if (mcu_wren !== 1'b0) begin errors++; $display("FAIL load_mcu_wren got=%b exp=0", mcu_wren); end
      step();
      data_req = 1'b0;
      @(negedge clock);
      checks++; if (data_rvalid !== 1'b1) begin errors++; $display("FAIL load_data_rvalid got=%b exp=1", data_rvalid); end
      checks++; if (data_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data_rdata got=%h exp=deadbeef", data_rdata); end
      checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL load_fetch_rvalid got=%b exp=0", fetch_rvalid); end
      step();
      @(negedge clock);
      checks++; if ({data_rvalid, data_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL load_hold got=%b/%h exp=0/deadbeef", data_rvalid, data_rdata); end
      step();
   endtask

   task automatic test_back_to_back();
      // Cycles 0..3 alternate fetch/data reads, cycle 4 idle.
      logic [4:0] is_fetch;
      logic [4:0] is_data;
      is_fetch = 5'b00101;
      is_data  = 5'b01010;
      fetch_address = 32'h8002_0000;
      data_address  = 32'h8002_0020; data_wren = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fetch_req = is_fetch[i];
         data_req  = is_data[i];
         @(negedge clock);
         checks++; if ({fetch_stall, data_stall} !== 2'b00) begin errors++; $display("FAIL b2b_stall[%0d] got=%b%b exp=00", i, fetch_stall, data_stall); end
         if (i > 0) begin
            checks++; if ({fetch_rvalid, data_rvalid} !== {is_fetch[i-1], is_data[i-1]}) begin errors++; $display("FAIL b2b_rvalid[%0d] got=%b%b exp=%b%b", i, fetch_rvalid, data_rvalid, is_fetch[i-1], is_data[i-1]); end
            if (is_fetch[i-1]) begin
               checks++; if (fetch_rdata !== 32'h2408_0005) begin errors++; $display("FAIL b2b_fetch_rdata[%0d] got=%h exp=24080005", i, fetch_rdata); end
            end else begin
               checks++; if (data_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_data_rdata[%0d] got=%h exp=deadbeef", i, data_rdata); end
            end
         end
         step();
      end
      fetch_req = 1'b0; data_req = 1'b0;
      step();
   endtask

   task automatic test_reset_inflight();
      fetch_req = 1'b1; fetch_address = 32'h8002_0000;
      step();
      reset = 1'b1;
      #1;
      checks++; if (booting !== 1'b1) begin errors++; $display("FAIL rst_booting got=%b exp=1", booting); end
      checks++; if ({fetch_stall, data_stall} !== 2'b11) begin errors++; $display("FAIL rst_stalls got=%b%b exp=11", fetch_stall, data_stall); end
      @(negedge clock);
      checks++; if ({fetch_rvalid, data_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_no_rvalid got=%b%b exp=00", fetch_rvalid, data_rvalid); end
      step();
      reset = 1'b0;
      loader_done = 1'b0;
      step();
      @(negedge clock);
      checks++; if (booting !== 1'b1) begin errors++; $display("FAIL rst_stay_boot got=%b exp=1", booting); end
      checks++; if ({fetch_stall, data_stall, fetch_rvalid} !== 3'b110) begin errors++; $display("FAIL rst_boot_outputs got=%b%b%b exp=110", fetch_stall, data_stall, fetch_rvalid); end
      loader_done = 1'b1;
      step();
      loader_done = 1'b0;
      @(negedge clock);
      checks++; if ({booting, fetch_stall} !== 2'b00) begin errors++; $display("FAIL rst_rerun got=%b%b exp=00", booting, fetch_stall); end
      fetch_req = 1'b0;
      step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_boot_load();
      test_boot_exit();
      test_starvation();
      test_store_load();
      test_back_to_back();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
